hex_line_receiver: RTL and testbench

- Receive side of the JTAG UART console. Consumes the byte stream from the alt_jtag_atlantic host-to-FPGA port (t_dat/t_ena/t_dav).
- Parses ASCII hexadecimal lines terminated by CR or LF and presents each completed line as one binary word on a valid/ready handshake.
- Used to feed numeric input to Reduceron I/O reads. It is the inverse of the existing hex-nibble-plus-CR/LF result transmitter.

---
 rtl/hex_line_receiver.sv | 104 ++++++++++
 tb/tb_hex_line_receiver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hex_line_receiver.sv
// rtl/hex_line_receiver.sv - ASCII hex line parser for the JTAG UART console receive path
// Each CR/LF-terminated line of hex digits is presented as one word on a valid/ready handshake.
module hex_line_receiver #(
   parameter int WIDTH  = 36,
   parameter int DIGITS = WIDTH / 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [WIDTH-1:0] word_o,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic             ovf_o,
   output logic             err_o
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] HOLD    = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic             ovf_flag;
   logic             bad;

   logic             is_hex;
   logic             is_term;
   logic [3:0]       nibble;
   logic             take;

   assign rx_ready = (state == COLLECT);
   assign take     = rx_valid && rx_ready;
   assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);

   always_comb begin
      is_hex = 1'b1;
      nibble = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         nibble = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 maps A..F to 10..15
         nibble = rx_data[3:0] + 4'd9;
      end else begin
         is_hex = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= COLLECT;
         acc          <= '0;
         count        <= '0;
         ovf_flag     <= 1'b0;
         bad          <= 1'b0;
         word_o       <= '0;
         word_valid_o <= 1'b0;
         ovf_o        <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (state == HOLD) begin
            if (word_valid_o && word_ready_i) begin
               word_valid_o <= 1'b0;
               state        <= COLLECT;
            end
         end else if (take) begin
            if (is_hex) begin
               // after an illegal character the line is doomed, so freeze the accumulator
               if (!bad) begin
                  acc <= {acc[WIDTH-5:0], nibble};
                  if (count == CW'(DIGITS)) begin
                     ovf_flag <= 1'b1;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end else if (is_term) begin
               if (bad) begin
                  err_o    <= 1'b1;
                  acc      <= '0;
                  count    <= '0;
                  ovf_flag <= 1'b0;
                  bad      <= 1'b0;
               end else if (count != '0) begin
                  word_o       <= acc;
                  ovf_o        <= ovf_flag;
                  word_valid_o <= 1'b1;
                  state        <= HOLD;
                  acc          <= '0;
                  count        <= '0;
                  ovf_flag     <= 1'b0;
               end
            end else begin
               bad <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_line_receiver.sv
// tb/tb_hex_line_receiver.sv - directed bench for hex_line_receiver
module tb_hex_line_receiver;

   localparam int WIDTH = 36;

   logic             clock = 1'b0;
   logic             rst_n;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [WIDTH-1:0] word_o;
   logic             word_valid_o;
   logic             word_ready_i;
   logic             ovf_o;
   logic             err_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   hex_line_receiver #(.WIDTH(WIDTH)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .ovf_o        (ovf_o),
      .err_o        (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // byte accepted on the posedge; returns #1 after it
   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      rx_data      = 8'h00;
      rx_valid     = 1'b0;
      word_ready_i = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_rx_ready", 64'(rx_ready), 64'd1);
      chk("rst_valid", 64'(word_valid_o), 64'd0);
      chk("rst_word", 64'(word_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      @(negedge clock);
      rst_n = 1'b1;

      // basic line, consumer ready
      word_ready_i = 1'b1;
      send_str("1A3F");
      send_byte(8'h0D);
      chk("t1_valid", 64'(word_valid_o), 64'd1);
      chk("t1_word", 64'(word_o), 64'h000001A3F);
      chk("t1_ovf", 64'(ovf_o), 64'd0);
      chk("t1_rx_ready_hold", 64'(rx_ready), 64'd0);
      tick();
      chk("t1_valid_drop", 64'(word_valid_o), 64'd0);
      chk("t1_rx_ready_back", 64'(rx_ready), 64'd1);

      // lower-case digits and CRLF
      send_str("abc");
      send_byte(8'h0D);
      chk("t2_valid", 64'(word_valid_o), 64'd1);
      chk("t2_word", 64'(word_o), 64'h000000ABC);
      tick();
      send_byte(8'h0A);
      chk("t2_lf_valid", 64'(word_valid_o), 64'd0);
      chk("t2_lf_err", 64'(err_o), 64'd0);
      tick();
      chk("t2_lf_valid2", 64'(word_valid_o), 64'd0);
      chk("t2_lf_err2", 64'(err_o), 64'd0);

      // overflow: ten digits into a nine-digit word
      send_str("123456789A");
      send_byte(8'h0A);
      chk("t3_valid", 64'(word_valid_o), 64'd1);
      chk("t3_word", 64'(word_o), 64'h23456789A);
      chk("t3_ovf", 64'(ovf_o), 64'd1);
      tick();
      send_str("7");
      send_byte(8'h0A);
      chk("t3b_word", 64'(word_o), 64'h7);
      chk("t3b_ovf", 64'(ovf_o), 64'd0);
      tick();

      // illegal character discards the line
      send_str("12G4");
      send_byte(8'h0D);
      chk("t4_err", 64'(err_o), 64'd1);
      chk("t4_valid", 64'(word_valid_o), 64'd0);
      tick();
      chk("t4_err_pulse", 64'(err_o), 64'd0);
      send_str("5");
      send_byte(8'h0D);
      chk("t4b_valid", 64'(word_valid_o), 64'd1);
      chk("t4b_word", 64'(word_o), 64'h5);
      tick();

      // backpressure with the byte source pushing throughout
      word_ready_i = 1'b0;
      send_str("FF");
      send_byte(8'h0D);
      chk("t5_valid", 64'(word_valid_o), 64'd1);
      @(negedge clock);
      rx_data  = 8'h31;
      rx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t5_rx_ready", 64'(rx_ready), 64'd0);
         chk("t5_word", 64'(word_o), 64'hFF);
         chk("t5_valid_hold", 64'(word_valid_o), 64'd1);
      end
      @(negedge clock);
      word_ready_i = 1'b1;
      tick();
      rx_valid = 1'b0;
      chk("t5_valid_drop", 64'(word_valid_o), 64'd0);
      chk("t5_rx_ready_back", 64'(rx_ready), 64'd1);

      // reset in the middle of a line
      send_str("12");
      @(negedge clock);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(word_valid_o), 64'd0);
      chk("t6_rst_word", 64'(word_o), 64'd0);
      chk("t6_rst_ovf", 64'(ovf_o), 64'd0);
      chk("t6_rst_err", 64'(err_o), 64'd0);
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      send_str("3");
      send_byte(8'h0D);
      chk("t6_valid", 64'(word_valid_o), 64'd1);
      chk("t6_word", 64'(word_o), 64'h3);
      chk("t6_ovf", 64'(ovf_o), 64'd0);
      chk("t6_err", 64'(err_o), 64'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
